// File: rtl/rr_grant_pkg.sv
// Shared definitions for the round-robin grant controller: FSM encoding,
// requester limit and the grant-index width helper.
package rr_grant_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } rr_state_e;

   localparam int RR_MAX_REQ = 16;

   // A single requester still gets a 1-bit index so ports never collapse to zero width.
   function automatic int rr_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_grant_ctrl_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping back to index 0.
module rr_pick
   import rr_grant_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDW     = rr_id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic               pick_valid,
   output logic [IDW-1:0]     pick_id
);

   logic           hi_v;
   logic [IDW-1:0] hi_id;
   logic           lo_v;
   logic [IDW-1:0] lo_id;

   // Scan downward so the lowest qualifying index is written last and wins.
   always_comb begin
      hi_v  = 1'b0;
      hi_id = '0;
      lo_v  = 1'b0;
      lo_id = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_v  = 1'b1;
            lo_id = IDW'(i);
            if (IDW'(i) >= ptr) begin
               hi_v  = 1'b1;
               hi_id = IDW'(i);
            end
         end
      end
   end

   assign pick_valid = lo_v;
   assign pick_id    = hi_v ? hi_id : lo_id;

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: one registered one-hot grant at a time, held
// until done, withdraw or hold timeout, with a rotating priority pointer.
module rr_grant_ctrl
   import rr_grant_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic                           done,
   output logic [NUM_REQ-1:0]             gnt,
   output logic                           gnt_valid,
   output logic [rr_id_w(NUM_REQ)-1:0]    gnt_id,
   output logic                           busy,
   output logic                           timeout,
   output logic [1:0]                     state_dbg,
   output logic [rr_id_w(NUM_REQ)-1:0]    ptr_dbg
);

   localparam int             IDW       = rr_id_w(NUM_REQ);
   localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
   localparam logic [7:0]     HOLD_LAST = 8'(MAX_HOLD - 1);

   // Handshake: req is a level held by the agent; gnt is the registered answer.
   // A request is served from the cycle gnt rises until done, the agent drops
   // its req bit, or the hold limit is reached; then gnt falls for >= 2 cycles.

   rr_state_e          state_q, state_d;
   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               gnt_valid_q, gnt_valid_d;
   logic [IDW-1:0]     gnt_id_q, gnt_id_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic               pick_valid;
   logic [IDW-1:0]     pick_id;
   logic               withdraw;
   logic               hold_hit;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_pick (
      .req        (req),
      .ptr        (ptr_q),
      .pick_valid (pick_valid),
      .pick_id    (pick_id)
   );

   assign withdraw = ((req & gnt_q) == '0);
   assign hold_hit = (cnt_q == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_id_d    = gnt_id_q;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d     = GRANT;
               gnt_d       = NUM_REQ'(1) << pick_id;
               gnt_valid_d = 1'b1;
               gnt_id_d    = pick_id;
               cnt_d       = '0;
            end
         end
         GRANT: begin
            cnt_d = cnt_q + 8'd1;
            if (done || withdraw || hold_hit) begin
               state_d     = RELEASE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               // Timeout only reports a revocation nothing else explains.
               timeout_d   = !done && !withdraw;
            end
         end
         RELEASE: begin
            state_d = IDLE;
            ptr_d   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = busy_q;
   assign timeout   = timeout_q;
   assign state_dbg = state_q;
   assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl (NUM_REQ=4, MAX_HOLD=16): table of per-cycle vectors
// with expected outputs, plus a hand-written timeout/reissue sequence.
module tb_rr_grant_ctrl;

   localparam logic [1:0] S_I = 2'd0;
   localparam logic [1:0] S_G = 2'd1;
   localparam logic [1:0] S_R = 2'd2;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic       busy;
   logic       timeout;
   logic [1:0] state_dbg;
   logic [1:0] ptr_dbg;

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic        done;
      logic [12:0] exp;
   } vec_t;

   vec_t        vec_q[$];
   logic [12:0] exp_q[$];
   int          n_vec;
   int          n_err;

   rr_grant_ctrl #(
      .NUM_REQ  (4),
      .MAX_HOLD (16)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .busy      (busy),
      .timeout   (timeout),
      .state_dbg (state_dbg),
      .ptr_dbg   (ptr_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected word: {state, ptr, gnt, gnt_valid, gnt_id, busy, timeout}
   function automatic logic [12:0] pk(input logic [1:0] st, input logic [1:0] p,
                                      input logic [3:0] g, input logic [1:0] id,
                                      input logic to);
      return {st, p, g, (g != 4'b0), id, (st != S_I), to};
   endfunction

   function automatic logic [12:0] actual();
      return {state_dbg, ptr_dbg, gnt, gnt_valid, gnt_id, busy, timeout};
   endfunction

   task automatic add(input logic rst_n, input logic [3:0] r, input logic d,
                      input logic [1:0] st, input logic [1:0] p, input logic [3:0] g,
                      input logic [1:0] id, input logic to);
      vec_t v;
      v.rst_n = rst_n;
      v.req   = r;
      v.done  = d;
      v.exp   = pk(st, p, g, id, to);
      vec_q.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [12:0] act,
                        input logic [12:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s #%0d: got st=%0d ptr=%0d gnt=%b gv=%b id=%0d busy=%b to=%b, want st=%0d ptr=%0d gnt=%b gv=%b id=%0d busy=%b to=%b",
                  name, idx, act[12:11], act[10:9], act[8:5], act[4], act[3:2], act[1], act[0],
                  exp[12:11], exp[10:9], exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
      end
   endtask

   // driver: apply inputs, queue the post-edge expectation, compare after the edge
   task automatic drive_vec(input vec_t v, input int idx);
      logic [12:0] e;
      reset_n = v.rst_n;
      req     = v.req;
      done    = v.done;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("vec", idx, actual(), e);
   endtask

   task automatic fill_table();
      logic [1:0] k2, n2;
      // reset with all requests pending, then first grant to 0
      repeat (3) add(1'b0, 4'hF, 1'b0, S_I, 2'd0, 4'b0000, 2'd0, 1'b0);
      add(1'b1, 4'hF, 1'b0, S_G, 2'd0, 4'b0001, 2'd0, 1'b0);
      // rotation 0,1,2,3,0 with done two cycles after each grant
      for (int k = 0; k < 4; k++) begin
         k2 = 2'(k);
         n2 = 2'((k + 1) % 4);
         add(1'b1, 4'hF, 1'b0, S_G, k2, 4'b0001 << k2, k2, 1'b0);
         add(1'b1, 4'hF, 1'b0, S_G, k2, 4'b0001 << k2, k2, 1'b0);
         add(1'b1, 4'hF, 1'b1, S_R, k2, 4'b0000, k2, 1'b0);
         add(1'b1, 4'hF, 1'b0, S_I, n2, 4'b0000, k2, 1'b0);
         add(1'b1, 4'hF, 1'b0, S_G, n2, 4'b0001 << n2, n2, 1'b0);
      end
      add(1'b1, 4'hF, 1'b1, S_R, 2'd0, 4'b0000, 2'd0, 1'b0);
      add(1'b1, 4'h0, 1'b0, S_I, 2'd1, 4'b0000, 2'd0, 1'b0);
      // withdraw, req change ignored in RELEASE, then ptr=2 picks requester 3
      add(1'b1, 4'b0010, 1'b0, S_G, 2'd1, 4'b0010, 2'd1, 1'b0);
      add(1'b1, 4'b0010, 1'b0, S_G, 2'd1, 4'b0010, 2'd1, 1'b0);
      add(1'b1, 4'b0000, 1'b0, S_R, 2'd1, 4'b0000, 2'd1, 1'b0);
      add(1'b1, 4'b1001, 1'b0, S_I, 2'd2, 4'b0000, 2'd1, 1'b0);
      add(1'b1, 4'b1001, 1'b0, S_G, 2'd2, 4'b1000, 2'd3, 1'b0);
      add(1'b1, 4'b1001, 1'b1, S_R, 2'd2, 4'b0000, 2'd3, 1'b0);
      add(1'b1, 4'b0000, 1'b1, S_I, 2'd0, 4'b0000, 2'd3, 1'b0);
      add(1'b1, 4'b0000, 1'b1, S_I, 2'd0, 4'b0000, 2'd3, 1'b0);
      // done coinciding with the hold limit: no timeout pulse
      add(1'b1, 4'b0100, 1'b0, S_G, 2'd0, 4'b0100, 2'd2, 1'b0);
      repeat (15) add(1'b1, 4'b0100, 1'b0, S_G, 2'd0, 4'b0100, 2'd2, 1'b0);
      add(1'b1, 4'b0100, 1'b1, S_R, 2'd0, 4'b0000, 2'd2, 1'b0);
      add(1'b1, 4'b0100, 1'b0, S_I, 2'd3, 4'b0000, 2'd2, 1'b0);
      // full-length grant ending in timeout, then reissue after two gap cycles
      add(1'b1, 4'b0100, 1'b0, S_G, 2'd3, 4'b0100, 2'd2, 1'b0);
      repeat (15) add(1'b1, 4'b0100, 1'b0, S_G, 2'd3, 4'b0100, 2'd2, 1'b0);
      add(1'b1, 4'b0100, 1'b0, S_R, 2'd3, 4'b0000, 2'd2, 1'b1);
      add(1'b1, 4'b0100, 1'b0, S_I, 2'd3, 4'b0000, 2'd2, 1'b0);
      add(1'b1, 4'b0100, 1'b0, S_G, 2'd3, 4'b0100, 2'd2, 1'b0);
      // reset on the very edge the hold limit would fire
      repeat (15) add(1'b1, 4'b0100, 1'b0, S_G, 2'd3, 4'b0100, 2'd2, 1'b0);
      add(1'b0, 4'b0100, 1'b0, S_I, 2'd0, 4'b0000, 2'd0, 1'b0);
      add(1'b1, 4'b0000, 1'b0, S_I, 2'd0, 4'b0000, 2'd0, 1'b0);
      add(1'b1, 4'b0001, 1'b1, S_G, 2'd0, 4'b0001, 2'd0, 1'b0);
      add(1'b1, 4'b0001, 1'b1, S_R, 2'd0, 4'b0000, 2'd0, 1'b0);
      add(1'b1, 4'b0000, 1'b0, S_I, 2'd1, 4'b0000, 2'd0, 1'b0);
   endtask

   // hand-written sequence: grant length and single timeout pulse, bounded wait
   task automatic timeout_seq();
      int gnt_cycles;
      int to_seen;
      reset_n    = 1'b1;
      req        = 4'b0100;
      done       = 1'b0;
      gnt_cycles = 0;
      to_seen    = 0;
      for (int c = 0; c < 40 && to_seen == 0; c++) begin
         @(posedge clk);
         #1;
         if (gnt == 4'b0100) gnt_cycles++;
         if (timeout) to_seen++;
      end
      n_vec++;
      if (to_seen != 1) begin
         n_err++;
         $display("FAIL timeout_wait: got %0d pulses within 40 cycles, want 1", to_seen);
      end
      n_vec++;
      if (gnt_cycles != 16) begin
         n_err++;
         $display("FAIL hold_len: got %0d grant cycles, want 16", gnt_cycles);
      end
      @(posedge clk);
      #1;
      check("gap_idle", 0, actual(), pk(S_I, 2'd3, 4'b0000, 2'd2, 1'b0));
      @(posedge clk);
      #1;
      check("reissue", 0, actual(), pk(S_G, 2'd3, 4'b0100, 2'd2, 1'b0));
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      req     = 4'b0;
      done    = 1'b0;
      fill_table();
      @(negedge clk);
      for (int i = 0; i < vec_q.size(); i++) drive_vec(vec_q[i], i);
      timeout_seq();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin grant controller that shares the design's single synchronous processing resource among `NUM_REQ` requesters. It sits between the requesting agents and the resource. It issues one registered one-hot grant at a time and holds that grant until the resource signals completion, the requester withdraws, or a hold timeout expires. Fairness is guaranteed by a rotating priority pointer.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal values are 1 to 16.
- `MAX_HOLD`, default 16: maximum number of cycles a grant may be held; legal values are 2 to 255.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `reset_n`, input, 1: reset, synchronous and active-low.
- `req`, input, `NUM_REQ`: per-requester request, level-sensitive.
- `done`, input, 1: one-cycle pulse from the resource meaning the current job is finished.
- `gnt`, output, `NUM_REQ`: one-hot grant, registered.
- `gnt_valid`, output, 1: high while any grant is active.
- `gnt_id`, output, `$clog2(NUM_REQ)` bits (minimum 1): index of the granted requester.
- `busy`, output, 1: high in every state except IDLE.
- `timeout`, output, 1: one-cycle pulse when a grant is revoked because it reached `MAX_HOLD`.

## Operation
- **Reset values** (applied at the first rising edge with `reset_n`=0): state=IDLE, `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `busy`=0, `timeout`=0, priority pointer `ptr`=0, hold counter=0.
- **FSM states:** IDLE, GRANT, RELEASE.
- **IDLE**
  - If `req`≠0, select the first set bit scanning from `ptr` upward, wrapping at `NUM_REQ`-1 → 0.
  - Register that bit into `gnt`, its index into `gnt_id`, set `gnt_valid`=1, clear the counter, and go to GRANT.
- **GRANT**
  - The counter increments every cycle.
  - Exit to RELEASE on the first of these conditions:
    - (a) `done`=1;
    - (b) `req[gnt_id]`=0, meaning the requester withdrew;
    - (c) counter = `MAX_HOLD`-1, which also pulses `timeout` in the cycle RELEASE is entered.
  - Priority when conditions coincide: `done` > withdraw > timeout. `timeout` pulses only if neither `done` nor withdraw is also true that cycle.
- **RELEASE**
  - Lasts exactly one cycle: `gnt`=0, `gnt_valid`=0, `busy`=1, `gnt_id` holds its last value.
  - Set `ptr` = (`gnt_id`+1) mod `NUM_REQ`, then return to IDLE.
- `done` is ignored in IDLE and RELEASE.
- Changes to `req` are ignored during RELEASE; `req` is only sampled in IDLE and for withdraw detection.
- With `NUM_REQ`=1 the pointer stays at 0 and the block behaves as a request/done/timeout sequencer.
- **Reset mid-operation:** any state returns to IDLE with all outputs at reset values at the next edge. No `timeout` pulse is produced and no partial grant is retained.

## Timing
- Request-to-grant latency is 1 cycle: `req` seen in IDLE at edge N gives `gnt` high after edge N+1.
- Grant turnaround is 3 cycles minimum:
  - GRANT ends on `done` (or another exit condition);
  - one RELEASE cycle;
  - one IDLE cycle for arbitration;
  - the next grant appears.
- Back-to-back grants to different requesters are therefore always separated by at least 2 cycles with `gnt`=0.
- A grant with no `done` and no withdraw lasts exactly `MAX_HOLD` cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `rr_grant_pkg` contains:
  - the state enum `rr_state_e` (IDLE, GRANT, RELEASE);
  - the constant `RR_MAX_REQ`=16;
  - the function for `gnt_id` width.
- Sub-module `rr_pick`: a purely combinational rotating-priority picker.
  - Inputs: `req` and `ptr`.
  - Outputs: `pick_valid` and `pick_id`.
  - It is instantiated once, and the top FSM registers its result.

## Test plan
- **Reset:** drive `req`=4'b1111, assert `reset_n`=0 for 3 cycles → all outputs 0 and `ptr`=0; after release, the first grant is `gnt`=4'b0001 with `gnt_id`=0 one cycle later.
- **Rotation:** hold `req`=4'b1111 and pulse `done` 2 cycles after each grant → grant order is 0, 1, 2, 3, 0, with each grant 3 cycles long and 2 idle cycles between grants.
- **Timeout:** `req`=4'b0100, `MAX_HOLD`=16, no `done` → `gnt`=4'b0100 for exactly 16 cycles, `timeout` pulses once, then the grant is reissued to requester 2 after 2 gap cycles.
- **Simultaneous exit:** `done`=1 in the same cycle the counter reaches `MAX_HOLD`-1 → RELEASE entered with `timeout`=0.
- **Withdraw:** `req` drops from 4'b0010 to 0 while granted → `gnt` cleared 1 cycle later; then `req`=4'b1001 with `ptr`=2 → requester 3 granted.
- **Mid-operation reset:** `reset_n`=0 for one cycle while in GRANT → the next edge shows IDLE with all outputs 0 and no `timeout` pulse.
